// File: rtl/ex_muldiv_unit_if.sv
// Request/response bundle between decode, the mul/div unit and the EX-MEM buffer.
// The slave modport is the unit; the master modport is the pipeline side driving it.
interface ex_muldiv_unit_if #(
  parameter int XLEN = 32
);
  logic            req_valid_ip;
  logic            req_ready_op;
  logic [2:0]      req_op_ip;
  logic [XLEN-1:0] req_a_ip;
  logic [XLEN-1:0] req_b_ip;
  logic [4:0]      req_rd_ip;
  logic            flush_ip;
  logic            busy_op;
  logic            resp_valid_op;
  logic            resp_ready_ip;
  logic [XLEN-1:0] resp_result_op;
  logic [4:0]      resp_rd_op;

  modport master (
    output req_valid_ip, req_op_ip, req_a_ip, req_b_ip, req_rd_ip, flush_ip, resp_ready_ip,
    input  req_ready_op, busy_op, resp_valid_op, resp_result_op, resp_rd_op
  );

  modport slave (
    input  req_valid_ip, req_op_ip, req_a_ip, req_b_ip, req_rd_ip, flush_ip, resp_ready_ip,
    output req_ready_op, busy_op, resp_valid_op, resp_result_op, resp_rd_op
  );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide on
// magnitudes, sign fixup in a final cycle, divide special cases answered directly.
module ex_muldiv_unit #(
  parameter int XLEN = 32,
  parameter int STEP = 1
) (
  input  logic              clock,
  input  logic              reset,
  ex_muldiv_unit_if.slave   bus
);
  localparam int NCYC  = XLEN / STEP;
  localparam int CNT_W = $clog2(NCYC + 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIXUP, S_DONE} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [2:0]          r_op;
  logic                r_sa;
  logic                r_sb;
  logic [XLEN-1:0]     r_opb;
  logic [2*XLEN-1:0]   r_acc;
  logic [XLEN-1:0]     r_result;
  logic [4:0]          r_rd;

  logic                w_accept;
  logic                w_req_ready;
  logic                w_busy;
  logic                w_resp_valid;
  logic                w_a_signed;
  logic                w_b_signed;
  logic                w_sa;
  logic                w_sb;
  logic [XLEN-1:0]     w_abs_a;
  logic [XLEN-1:0]     w_abs_b;
  logic                w_div0;
  logic                w_ovf;
  logic                w_special;
  logic [XLEN-1:0]     w_special_res;
  logic [2*XLEN-1:0]   w_acc_nxt;
  logic [XLEN:0]       w_trial;
  logic [XLEN:0]       w_sum;
  logic [2*XLEN-1:0]   w_prod;
  logic [XLEN-1:0]     w_quo;
  logic [XLEN-1:0]     w_rem;
  logic [XLEN-1:0]     w_fix_res;

  // Operand decode on the incoming request
  assign w_a_signed = (bus.req_op_ip == 3'd1) || (bus.req_op_ip == 3'd2) ||
                      (bus.req_op_ip == 3'd4) || (bus.req_op_ip == 3'd6);
  assign w_b_signed = (bus.req_op_ip == 3'd1) || (bus.req_op_ip == 3'd4) ||
                      (bus.req_op_ip == 3'd6);
  assign w_sa       = w_a_signed & bus.req_a_ip[XLEN-1];
  assign w_sb       = w_b_signed & bus.req_b_ip[XLEN-1];
  assign w_abs_a    = w_sa ? (~bus.req_a_ip + 1'b1) : bus.req_a_ip;
  assign w_abs_b    = w_sb ? (~bus.req_b_ip + 1'b1) : bus.req_b_ip;
  assign w_div0     = bus.req_op_ip[2] && (bus.req_b_ip == '0);
  assign w_ovf      = ((bus.req_op_ip == 3'd4) || (bus.req_op_ip == 3'd6)) &&
                      (bus.req_a_ip == {1'b1, {(XLEN-1){1'b0}}}) && (bus.req_b_ip == '1);
  assign w_special  = w_div0 || w_ovf;
  assign w_special_res = w_div0 ? (bus.req_op_ip[1] ? bus.req_a_ip : '1)
                                : (bus.req_op_ip[1] ? '0 : bus.req_a_ip);
  assign w_accept   = (r_state == S_IDLE) && bus.req_valid_ip && !bus.flush_ip;

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_req_ready  = (r_state == S_IDLE);
    w_busy       = (r_state != S_IDLE);
    w_resp_valid = (r_state == S_DONE) && !bus.flush_ip;
    unique case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = w_special ? S_DONE : S_CALC;
      S_CALC:  if (r_cnt == CNT_W'(1)) w_state_nxt = S_FIXUP;
      S_FIXUP: w_state_nxt = S_DONE;
      S_DONE:  if (bus.resp_ready_ip) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (bus.flush_ip) w_state_nxt = S_IDLE;
  end

  // Iteration: acc holds {hi, multiplier} for mul and {rem, quo} for div
  always_comb begin
    w_acc_nxt = r_acc;
    w_trial   = '0;
    w_sum     = '0;
    for (int k = 0; k < STEP; k++) begin
      if (r_op[2]) begin
        w_trial = {w_acc_nxt[2*XLEN-1:XLEN], w_acc_nxt[XLEN-1]} - {1'b0, r_opb};
        if (!w_trial[XLEN]) w_acc_nxt = {w_trial[XLEN-1:0], w_acc_nxt[XLEN-2:0], 1'b1};
        else                w_acc_nxt = {w_acc_nxt[2*XLEN-2:0], 1'b0};
      end else begin
        w_sum     = {1'b0, w_acc_nxt[2*XLEN-1:XLEN]} + (w_acc_nxt[0] ? {1'b0, r_opb} : '0);
        w_acc_nxt = {w_sum, w_acc_nxt[XLEN-1:1]};
      end
    end
  end

  assign w_prod = (r_sa ^ r_sb) ? (~r_acc + 1'b1) : r_acc;
  assign w_quo  = (r_sa ^ r_sb) ? (~r_acc[XLEN-1:0] + 1'b1) : r_acc[XLEN-1:0];
  assign w_rem  = r_sa ? (~r_acc[2*XLEN-1:XLEN] + 1'b1) : r_acc[2*XLEN-1:XLEN];

  always_comb begin
    w_fix_res = w_prod[XLEN-1:0];
    unique case (r_op)
      3'd0:             w_fix_res = w_prod[XLEN-1:0];
      3'd1, 3'd2, 3'd3: w_fix_res = w_prod[2*XLEN-1:XLEN];
      3'd4, 3'd5:       w_fix_res = w_quo;
      default:          w_fix_res = w_rem;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt    <= '0;
      r_result <= '0;
      r_rd     <= '0;
    end else if (w_accept) begin
      r_cnt <= CNT_W'(NCYC);
      r_rd  <= bus.req_rd_ip;
      if (w_special) r_result <= w_special_res;
    end else if (r_state == S_CALC) begin
      r_cnt <= r_cnt - 1'b1;
    end else if ((r_state == S_FIXUP) && !bus.flush_ip) begin
      r_result <= w_fix_res;
    end
  end

  // Operand registers are sampled once at acceptance and only iterated afterwards
  always_ff @(posedge clock) begin
    if (w_accept) begin
      r_op <= bus.req_op_ip;
      r_sa <= w_sa;
      r_sb <= w_sb;
      if (bus.req_op_ip[2]) begin
        r_acc <= {{XLEN{1'b0}}, w_abs_a};
        r_opb <= w_abs_b;
      end else begin
        r_acc <= {{XLEN{1'b0}}, w_abs_b};
        r_opb <= w_abs_a;
      end
    end else if (r_state == S_CALC) begin
      r_acc <= w_acc_nxt;
    end
  end

  assign bus.req_ready_op   = w_req_ready;
  assign bus.busy_op        = w_busy;
  assign bus.resp_valid_op  = w_resp_valid;
  assign bus.resp_result_op = r_result;
  assign bus.resp_rd_op     = r_rd;
endmodule
